id_ex_pipe: RTL and testbench
=============================

Name: id_ex_pipe

Overview:
- ID/EX pipeline register for the 5-stage MIPS core, with load-use hazard detection built in.
- Captures decoded operands and control from ID each cycle. Feeds the EX-stage destination-select mux (rt/rd) and the ALU-source mux (register data 2 / immediate).
- On a load-use hazard it inserts one bubble and stalls PC and IF/ID. On a taken-branch flush it squashes the ID instruction.

Parameters:
- DATA_W, 32, operand and immediate width
- REG_W, 5, register-specifier width
- ALUOP_W, 3, ALU operation code width
- CNT_W, 16, bubble performance-counter width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  ID holds a real instruction
- in_flush  input  1  taken branch/jump; squash the ID instruction
- in_rs, in_rt, in_rd  input  REG_W  register specifiers from decode
- in_uses_rt  input  1  the instruction reads rt as a source (R-type, store, beq)
- in_dr1, in_dr2  input  DATA_W  register-file read data
- in_imm  input  DATA_W  sign-extended immediate
- in_reg_dst, in_alu_src, in_mem_read, in_mem_write, in_reg_write, in_mem_to_reg  input  1  control bits
- in_alu_op  input  ALUOP_W  ALU control
- out_valid  output  1  EX holds a real instruction
- out_rs, out_rt, out_rd  output  REG_W  registered specifiers
- out_dr1, out_dr2, out_imm  output  DATA_W  registered data
- out_reg_dst, out_alu_src, out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg  output  1  registered control
- out_alu_op  output  ALUOP_W  registered ALU control
- out_stall  output  1  combinational; hold PC and IF/ID this cycle
- out_bubble_cnt  output  CNT_W  saturating count of bubbles inserted

Behaviour:
- Reset: clk and reset are the only clock/reset. Reset is asynchronous and active-high. While reset=1, every registered output is 0, including out_valid and out_bubble_cnt. out_stall is 0 while reset=1.
- Hazard condition (combinational), haz = all of:
  - in_valid
  - out_valid
  - out_mem_read
  - out_rt != 0
  - (out_rt == in_rs) OR (in_uses_rt AND out_rt == in_rt)
- out_stall = haz AND NOT in_flush. Flush has priority: the ID instruction is being discarded, so there is nothing to stall for.
- Per rising edge (not in reset), in priority order:
  1. in_flush=1: load bubble.
  2. haz=1: load bubble; increment out_bubble_cnt.
  3. Otherwise: capture all in_* into out_*; out_valid <= in_valid.
- Bubble definition:
  - Zeroed: out_valid, out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg, out_reg_dst, out_alu_src, out_alu_op.
  - Still captured from in_*: out_rs, out_rt, out_rd, out_dr1, out_dr2, out_imm. These are don't-care to the checker when out_valid=0.
- Flush bubbles do not count.
- Latency: 1 cycle, ID to EX.
- A stall lasts exactly one cycle per load. The bubble clears out_mem_read, so haz drops on the next cycle. The held instruction then advances; forwarding from MEM resolves the operand.
- Back-to-back loads with dependence: each dependent consumer costs exactly one bubble.
- in_valid=0 in ID: no hazard; all in_* are captured; out_valid=0.
- Register 0 as destination never causes a stall.
- Counter saturates at all-ones and does not wrap.
- Reset asserted mid-stall: outputs clear immediately. After deassertion, no hazard exists until a new load reaches EX.

Decomposition:
- Shared package mips_pkg:
  - width constants DATA_W, REG_W, ALUOP_W
  - REG_ZERO = 5'd0
  - ALU op encodings
  - control-bundle field order
- Sub-module hazard_load_use: purely combinational. Inputs are the EX-stage rt/mem_read/valid and the ID-stage rs/rt/uses_rt/valid/flush. Outputs are haz and out_stall. Instantiated once.

Test Plan:
1. Reset: assert reset mid-cycle with nonzero state -> all outputs 0 immediately, before any clock edge; out_stall=0.
2. Pass-through: in_valid=1, rt=5, rd=9, dr2=0x1234, imm=0xFFFFFFF0, reg_dst=1, alu_src=0 -> next edge: out_* equal the inputs; out_valid=1; out_stall=0.
3. Load-use on rs:
   - EX holds lw with rt=8, mem_read=1; ID has in_rs=8.
   - -> out_stall=1 this cycle.
   - -> next edge: bubble (out_valid=0, controls 0); out_bubble_cnt=1.
   - -> following cycle: out_stall=0 and the instruction is captured.
4. rt only checked when used:
   - lw rt=8 in EX; ID has in_rt=8, in_uses_rt=0 -> no stall.
   - Same with in_uses_rt=1 -> stall.
   - lw rt=0 in EX with matching rs=0 -> no stall.
5. Flush beats hazard: hazard present plus in_flush=1 -> out_stall=0; next edge: bubble; out_bubble_cnt unchanged.
6. Saturation: preload the counter near max (force or CNT_W=2), then 5 hazards -> count stops at 3.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared widths, register-zero constant, ALU encodings and control-bundle
// layout for the 5-stage MIPS core.
package mips_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int ALUOP_W = 3;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [2:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_ADD = 3'd2,
    ALU_XOR = 3'd3,
    ALU_NOR = 3'd4,
    ALU_SUB = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_e;

  // Bit positions of the single-bit controls inside the packed control bundle.
  localparam int CTRL_REG_DST    = 0;
  localparam int CTRL_ALU_SRC    = 1;
  localparam int CTRL_MEM_READ   = 2;
  localparam int CTRL_MEM_WRITE  = 3;
  localparam int CTRL_REG_WRITE  = 4;
  localparam int CTRL_MEM_TO_REG = 5;
  localparam int CTRL_BITS       = 6;

endpackage

// File: rtl/hazard_load_use.sv
// Combinational load-use detector: a load in EX whose destination is read by
// the valid instruction in ID forces one bubble, unless ID is being flushed.
module hazard_load_use
  import mips_pkg::*;
#(
  parameter int REG_W = mips_pkg::REG_W
) (
  input  logic [REG_W-1:0] i_ex_rt,
  input  logic             i_ex_mem_read,
  input  logic             i_ex_valid,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_id_uses_rt,
  input  logic             i_id_valid,
  input  logic             i_id_flush,
  output logic             o_haz,
  output logic             o_stall
);

  logic w_rs_match;
  logic w_rt_match;
  logic w_ex_load;

  // $zero is never a real destination, so a load targeting it cannot create a dependence.
  assign w_ex_load  = i_ex_valid && i_ex_mem_read && (i_ex_rt != REG_W'(REG_ZERO));
  assign w_rs_match = (i_ex_rt == i_id_rs);
  assign w_rt_match = i_id_uses_rt && (i_ex_rt == i_id_rt);

  assign o_haz   = i_id_valid && w_ex_load && (w_rs_match || w_rt_match);
  assign o_stall = o_haz && !i_id_flush;

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with built-in load-use bubble insertion and a
// saturating count of inserted hazard bubbles.
module id_ex_pipe
  import mips_pkg::*;
#(
  parameter int DATA_W  = mips_pkg::DATA_W,
  parameter int REG_W   = mips_pkg::REG_W,
  parameter int ALUOP_W = mips_pkg::ALUOP_W,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               in_flush,
  input  logic [REG_W-1:0]   in_rs,
  input  logic [REG_W-1:0]   in_rt,
  input  logic [REG_W-1:0]   in_rd,
  input  logic               in_uses_rt,
  input  logic [DATA_W-1:0]  in_dr1,
  input  logic [DATA_W-1:0]  in_dr2,
  input  logic [DATA_W-1:0]  in_imm,
  input  logic               in_reg_dst,
  input  logic               in_alu_src,
  input  logic               in_mem_read,
  input  logic               in_mem_write,
  input  logic               in_reg_write,
  input  logic               in_mem_to_reg,
  input  logic [ALUOP_W-1:0] in_alu_op,
  output logic               out_valid,
  output logic [REG_W-1:0]   out_rs,
  output logic [REG_W-1:0]   out_rt,
  output logic [REG_W-1:0]   out_rd,
  output logic [DATA_W-1:0]  out_dr1,
  output logic [DATA_W-1:0]  out_dr2,
  output logic [DATA_W-1:0]  out_imm,
  output logic               out_reg_dst,
  output logic               out_alu_src,
  output logic               out_mem_read,
  output logic               out_mem_write,
  output logic               out_reg_write,
  output logic               out_mem_to_reg,
  output logic [ALUOP_W-1:0] out_alu_op,
  output logic               out_stall,
  output logic [CNT_W-1:0]   out_bubble_cnt
);

  logic                 r_valid;
  logic [REG_W-1:0]     r_rs;
  logic [REG_W-1:0]     r_rt;
  logic [REG_W-1:0]     r_rd;
  logic [DATA_W-1:0]    r_dr1;
  logic [DATA_W-1:0]    r_dr2;
  logic [DATA_W-1:0]    r_imm;
  logic [CTRL_BITS-1:0] r_ctrl;
  logic [ALUOP_W-1:0]   r_alu_op;
  logic [CNT_W-1:0]     r_bubble_cnt;

  logic                 w_haz;
  logic                 w_stall;
  logic                 w_bubble;
  logic                 w_cnt_inc;
  logic [CTRL_BITS-1:0] w_ctrl_in;

  always_comb begin
    w_ctrl_in                  = '0;
    w_ctrl_in[CTRL_REG_DST]    = in_reg_dst;
    w_ctrl_in[CTRL_ALU_SRC]    = in_alu_src;
    w_ctrl_in[CTRL_MEM_READ]   = in_mem_read;
    w_ctrl_in[CTRL_MEM_WRITE]  = in_mem_write;
    w_ctrl_in[CTRL_REG_WRITE]  = in_reg_write;
    w_ctrl_in[CTRL_MEM_TO_REG] = in_mem_to_reg;
  end

  hazard_load_use #(
    .REG_W (REG_W)
  ) u_hazard (
    .i_ex_rt       (r_rt),
    .i_ex_mem_read (r_ctrl[CTRL_MEM_READ]),
    .i_ex_valid    (r_valid),
    .i_id_rs       (in_rs),
    .i_id_rt       (in_rt),
    .i_id_uses_rt  (in_uses_rt),
    .i_id_valid    (in_valid),
    .i_id_flush    (in_flush),
    .o_haz         (w_haz),
    .o_stall       (w_stall)
  );

  // Flush and hazard both squash the controls; only a hazard bubble is counted.
  assign w_bubble  = in_flush || w_haz;
  assign w_cnt_inc = w_haz && !in_flush && (r_bubble_cnt != {CNT_W{1'b1}});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_rd         <= '0;
      r_dr1        <= '0;
      r_dr2        <= '0;
      r_imm        <= '0;
      r_ctrl       <= '0;
      r_alu_op     <= '0;
      r_bubble_cnt <= '0;
    end else begin
      r_rs  <= in_rs;
      r_rt  <= in_rt;
      r_rd  <= in_rd;
      r_dr1 <= in_dr1;
      r_dr2 <= in_dr2;
      r_imm <= in_imm;
      if (w_bubble) begin
        r_valid  <= 1'b0;
        r_ctrl   <= '0;
        r_alu_op <= '0;
      end else begin
        r_valid  <= in_valid;
        r_ctrl   <= w_ctrl_in;
        r_alu_op <= in_alu_op;
      end
      if (w_cnt_inc) begin
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end
    end
  end

  assign out_valid      = r_valid;
  assign out_rs         = r_rs;
  assign out_rt         = r_rt;
  assign out_rd         = r_rd;
  assign out_dr1        = r_dr1;
  assign out_dr2        = r_dr2;
  assign out_imm        = r_imm;
  assign out_reg_dst    = r_ctrl[CTRL_REG_DST];
  assign out_alu_src    = r_ctrl[CTRL_ALU_SRC];
  assign out_mem_read   = r_ctrl[CTRL_MEM_READ];
  assign out_mem_write  = r_ctrl[CTRL_MEM_WRITE];
  assign out_reg_write  = r_ctrl[CTRL_REG_WRITE];
  assign out_mem_to_reg = r_ctrl[CTRL_MEM_TO_REG];
  assign out_alu_op     = r_alu_op;
  assign out_stall      = w_stall;
  assign out_bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed bench for id_ex_pipe: pass-through, load-use stalls, flush priority,
// counter saturation (CNT_W=2) and asynchronous reset.
module tb_id_ex_pipe;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int AW = 3;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_flush, in_uses_rt;
  logic [RW-1:0] in_rs, in_rt, in_rd;
  logic [DW-1:0] in_dr1, in_dr2, in_imm;
  logic          in_reg_dst, in_alu_src, in_mem_read, in_mem_write, in_reg_write, in_mem_to_reg;
  logic [AW-1:0] in_alu_op;
  logic          out_valid;
  logic [RW-1:0] out_rs, out_rt, out_rd;
  logic [DW-1:0] out_dr1, out_dr2, out_imm;
  logic          out_reg_dst, out_alu_src, out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg;
  logic [AW-1:0] out_alu_op;
  logic          out_stall;
  logic [CW-1:0] out_bubble_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  id_ex_pipe #(.DATA_W(DW), .REG_W(RW), .ALUOP_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_flush(in_flush),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_uses_rt(in_uses_rt),
    .in_dr1(in_dr1), .in_dr2(in_dr2), .in_imm(in_imm),
    .in_reg_dst(in_reg_dst), .in_alu_src(in_alu_src), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
    .in_alu_op(in_alu_op), .out_valid(out_valid), .out_rs(out_rs), .out_rt(out_rt),
    .out_rd(out_rd), .out_dr1(out_dr1), .out_dr2(out_dr2), .out_imm(out_imm),
    .out_reg_dst(out_reg_dst), .out_alu_src(out_alu_src), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_reg_write(out_reg_write),
    .out_mem_to_reg(out_mem_to_reg), .out_alu_op(out_alu_op), .out_stall(out_stall),
    .out_bubble_cnt(out_bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ID holds a valid non-load instruction reading rs (and rt if uses_rt).
  task automatic id_alu(input logic [RW-1:0] rs, input logic [RW-1:0] rt, input logic urt);
    in_valid = 1'b1; in_flush = 1'b0; in_rs = rs; in_rt = rt; in_rd = 5'd10; in_uses_rt = urt;
    in_dr1 = 32'h0000_1111; in_dr2 = 32'h0000_2222; in_imm = 32'h0000_0004;
    in_reg_dst = 1'b1; in_alu_src = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
    in_reg_write = 1'b1; in_mem_to_reg = 1'b0; in_alu_op = 3'd2;
  endtask

  // ID holds lw rt, imm(rs).
  task automatic id_load(input logic [RW-1:0] rs, input logic [RW-1:0] rt);
    in_valid = 1'b1; in_flush = 1'b0; in_rs = rs; in_rt = rt; in_rd = 5'd0; in_uses_rt = 1'b0;
    in_dr1 = 32'h0000_0100; in_dr2 = 32'h0; in_imm = 32'h0000_0008;
    in_reg_dst = 1'b0; in_alu_src = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b0;
    in_reg_write = 1'b1; in_mem_to_reg = 1'b1; in_alu_op = 3'd2;
  endtask

  initial begin
    reset = 1'b1;
    id_alu(5'd0, 5'd0, 1'b0);
    in_valid = 1'b0;
    repeat (2) tick();
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_cnt", 32'(out_bubble_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Pass-through
    id_alu(5'd3, 5'd5, 1'b1);
    in_rd = 5'd9; in_dr1 = 32'h0000_AAAA; in_dr2 = 32'h0000_1234; in_imm = 32'hFFFF_FFF0;
    #1;
    check("pt_stall", 32'(out_stall), 32'd0);
    tick();
    check("pt_valid", 32'(out_valid), 32'd1);
    check("pt_rs", 32'(out_rs), 32'd3);
    check("pt_rt", 32'(out_rt), 32'd5);
    check("pt_rd", 32'(out_rd), 32'd9);
    check("pt_dr1", out_dr1, 32'h0000_AAAA);
    check("pt_dr2", out_dr2, 32'h0000_1234);
    check("pt_imm", out_imm, 32'hFFFF_FFF0);
    check("pt_reg_dst", 32'(out_reg_dst), 32'd1);
    check("pt_alu_src", 32'(out_alu_src), 32'd0);
    check("pt_reg_write", 32'(out_reg_write), 32'd1);
    check("pt_alu_op", 32'(out_alu_op), 32'd2);
    check("pt_stall2", 32'(out_stall), 32'd0);

    // Load-use on rs
    id_load(5'd2, 5'd8);
    tick();
    check("lu_ex_memrd", 32'(out_mem_read), 32'd1);
    id_alu(5'd8, 5'd4, 1'b1);
    #1;
    check("lu_stall", 32'(out_stall), 32'd1);
    tick();
    check("lu_bub_valid", 32'(out_valid), 32'd0);
    check("lu_bub_memrd", 32'(out_mem_read), 32'd0);
    check("lu_bub_regwr", 32'(out_reg_write), 32'd0);
    check("lu_bub_regdst", 32'(out_reg_dst), 32'd0);
    check("lu_bub_aluop", 32'(out_alu_op), 32'd0);
    check("lu_cnt1", 32'(out_bubble_cnt), 32'd1);
    check("lu_stall_after", 32'(out_stall), 32'd0);
    tick();
    check("lu_adv_valid", 32'(out_valid), 32'd1);
    check("lu_adv_rs", 32'(out_rs), 32'd8);
    check("lu_adv_regdst", 32'(out_reg_dst), 32'd1);
    check("lu_adv_cnt", 32'(out_bubble_cnt), 32'd1);

    // rt only matters when used; $zero never stalls
    id_load(5'd1, 5'd8);
    tick();
    id_alu(5'd3, 5'd8, 1'b0);
    #1;
    check("rt_unused_stall", 32'(out_stall), 32'd0);
    in_uses_rt = 1'b1;
    #1;
    check("rt_used_stall", 32'(out_stall), 32'd1);
    in_uses_rt = 1'b0;
    tick();
    check("rt_unused_valid", 32'(out_valid), 32'd1);
    check("rt_unused_cnt", 32'(out_bubble_cnt), 32'd1);
    id_load(5'd1, 5'd0);
    tick();
    id_alu(5'd0, 5'd0, 1'b1);
    #1;
    check("r0_stall", 32'(out_stall), 32'd0);
    tick();
    check("r0_valid", 32'(out_valid), 32'd1);

    // Flush beats hazard
    id_load(5'd1, 5'd8);
    tick();
    id_alu(5'd8, 5'd2, 1'b0);
    in_flush = 1'b1;
    #1;
    check("fl_stall", 32'(out_stall), 32'd0);
    tick();
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_regwr", 32'(out_reg_write), 32'd0);
    check("fl_cnt", 32'(out_bubble_cnt), 32'd1);

    // Invalid ID instruction: no hazard, fields captured, out_valid=0
    id_load(5'd1, 5'd8);
    tick();
    id_alu(5'd8, 5'd6, 1'b1);
    in_valid = 1'b0;
    #1;
    check("inv_stall", 32'(out_stall), 32'd0);
    tick();
    check("inv_valid", 32'(out_valid), 32'd0);
    check("inv_rs", 32'(out_rs), 32'd8);
    check("inv_regdst", 32'(out_reg_dst), 32'd1);
    check("inv_cnt", 32'(out_bubble_cnt), 32'd1);

    // Saturation: five more hazards, 2-bit counter stops at 3
    for (int k = 1; k <= 5; k++) begin
      id_load(5'd1, 5'd8);
      tick();
      id_alu(5'd8, 5'd3, 1'b0);
      #1;
      check("sat_stall", 32'(out_stall), 32'd1);
      tick();
      check("sat_cnt", 32'(out_bubble_cnt), (k + 1 > 3) ? 32'd3 : 32'(k + 1));
    end

    // Asynchronous reset mid-stall
    id_load(5'd1, 5'd8);
    tick();
    id_alu(5'd8, 5'd3, 1'b0);
    #1;
    check("rst_pre_stall", 32'(out_stall), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_memrd", 32'(out_mem_read), 32'd0);
    check("rst_rt", 32'(out_rt), 32'd0);
    check("rst_dr1", out_dr1, 32'd0);
    check("rst_imm", out_imm, 32'd0);
    check("rst_cnt", 32'(out_bubble_cnt), 32'd0);
    check("rst_stall", 32'(out_stall), 32'd0);
    #1;
    reset = 1'b0;
    #1;
    check("rst_post_stall", 32'(out_stall), 32'd0);
    tick();
    check("rst_post_valid", 32'(out_valid), 32'd1);
    check("rst_post_rs", 32'(out_rs), 32'd8);
    check("rst_post_cnt", 32'(out_bubble_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
